// File: rtl/systolic_skew_feeder.sv
// Skew feeder for the systolic PE array. Row lane i and column lane j are
// delayed i and j cycles so operands enter the array as a diagonal wavefront.

// One lane: a DEPTH-stage chain carrying an A element, a B element and the valid bit.
module systolic_skew_lane #(
  parameter int DEPTH = 1,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          v_in,
  input  logic [DW-1:0] a_in,
  input  logic [DW-1:0] b_in,
  output logic          v_out,
  output logic [DW-1:0] a_out,
  output logic [DW-1:0] b_out
);
  logic [DEPTH-1:0]         vld_pipe;
  logic [DEPTH-1:0][DW-1:0] a_pipe;
  logic [DEPTH-1:0][DW-1:0] b_pipe;

  // Shift every cycle; data is zeroed on entry when the valid is low so bubbles carry no stale operands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe <= '0;
      a_pipe   <= '0;
      b_pipe   <= '0;
    end else begin
      vld_pipe[0] <= v_in;
      a_pipe[0]   <= v_in ? a_in : '0;
      b_pipe[0]   <= v_in ? b_in : '0;
      for (int s = 1; s < DEPTH; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        a_pipe[s]   <= a_pipe[s-1];
        b_pipe[s]   <= b_pipe[s-1];
      end
    end
  end

  assign v_out = vld_pipe[DEPTH-1];
  assign a_out = a_pipe[DEPTH-1];
  assign b_out = b_pipe[DEPTH-1];
endmodule

module systolic_skew_feeder #(
  parameter int N  = 8,
  parameter int DW = 8,
  parameter int KW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [KW-1:0]   k_len,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*DW-1:0] in_a,
  input  logic [N*DW-1:0] in_b,
  output logic [N*DW-1:0] a_left,
  output logic [N-1:0]    a_vld,
  output logic [N*DW-1:0] b_top,
  output logic [N-1:0]    b_vld,
  output logic            busy,
  output logic            done
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;

  state_t        state, state_n;
  logic [KW-1:0] k_q, k_n, cnt, cnt_n;
  logic [CW-1:0] dcnt, dcnt_n;
  logic          done_n;
  logic          acc;
  logic [N-1:0]  lane_v;

  assign in_ready = (state == FEED);
  assign busy     = (state != IDLE);
  assign acc      = in_valid && in_ready;

  // State, latched length, beat/drain counters and the registered done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      k_q   <= '0;
      cnt   <= '0;
      dcnt  <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      k_q   <= k_n;
      cnt   <= cnt_n;
      dcnt  <= dcnt_n;
      done  <= done_n;
    end
  end

  // Next-state: start only from a quiet IDLE (not while done is showing), drain N-1 cycles after the last beat.
  always_comb begin
    state_n = state;
    k_n     = k_q;
    cnt_n   = cnt;
    dcnt_n  = dcnt;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (start && (k_len != '0) && !done) begin
          k_n     = k_len;
          cnt_n   = '0;
          state_n = FEED;
        end
      end
      FEED: begin
        if (acc) begin
          if (cnt == k_q - KW'(1)) begin
            if (N == 1) begin
              done_n  = 1'b1;
              state_n = IDLE;
            end else begin
              dcnt_n  = CW'(N - 1);
              state_n = DRAIN;
            end
          end else begin
            cnt_n = cnt + KW'(1);
          end
        end
      end
      DRAIN: begin
        dcnt_n = dcnt - CW'(1);
        if (dcnt == CW'(1)) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Lane i has depth i+1; A and B of the same index share one valid chain.
  for (genvar i = 0; i < N; i++) begin : g_lane
    systolic_skew_lane #(.DEPTH(i + 1), .DW(DW)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .v_in  (acc),
      .a_in  (in_a[i*DW +: DW]),
      .b_in  (in_b[i*DW +: DW]),
      .v_out (lane_v[i]),
      .a_out (a_left[i*DW +: DW]),
      .b_out (b_top[i*DW +: DW])
    );
  end

  assign a_vld = lane_v;
  assign b_vld = lane_v;
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Scoreboard bench for systolic_skew_feeder: stimulus pushes per-lane expected
// beats (with their arrival cycle) and done cycles; a negedge monitor checks them.
`timescale 1ns/1ps
module tb_systolic_skew_feeder;
  localparam int N = 8, DW = 8, KW = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic [KW-1:0]   k_len = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [N*DW-1:0] in_a = '0, in_b = '0;
  logic [N*DW-1:0] a_left, b_top;
  logic [N-1:0]    a_vld, b_vld;
  logic            busy, done;

  systolic_skew_feeder #(.N(N), .DW(DW), .KW(KW)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .in_valid(in_valid),
    .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .a_left(a_left), .a_vld(a_vld),
    .b_top(b_top), .b_vld(b_vld), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int lane; int cyc; logic [7:0] a; logic [7:0] b;} exp_t;
  exp_t sb[$];
  int   done_q[$];
  int   errs = 0, checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s act=%h exp=%h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every valid lane must match the oldest expectation for that lane in value and cycle.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      int idx;
      idx = -1;
      if (a_vld[i] || b_vld[i]) begin
        for (int q = 0; q < sb.size(); q++)
          if (idx < 0 && sb[q].lane == i) idx = q;
        chk("lane_valid_pair", {63'd0, b_vld[i]}, {63'd0, a_vld[i]});
        if (idx < 0) begin
          chk("unexpected_lane_beat", 64'(i), 64'hFF);
        end else begin
          chk("lane_cycle", 64'(cyc), 64'(sb[idx].cyc));
          chk("a_left", {56'd0, a_left[i*DW +: DW]}, {56'd0, sb[idx].a});
          chk("b_top", {56'd0, b_top[i*DW +: DW]}, {56'd0, sb[idx].b});
          sb.delete(idx);
        end
      end else begin
        chk("bubble_zero", {48'd0, a_left[i*DW +: DW], b_top[i*DW +: DW]}, 64'd0);
      end
    end
    if (done) begin
      if (done_q.size() == 0) chk("unexpected_done", 64'(cyc), 64'hFFFF);
      else begin
        chk("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
        chk("busy_at_done", {63'd0, busy}, 64'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] mk_a(input int k);
    logic [63:0] v;
    for (int i = 0; i < N; i++) v[i*8 +: 8] = 8'(8'h10 * k + i);
    return v;
  endfunction

  function automatic logic [63:0] mk_b(input int k);
    logic [63:0] v;
    for (int i = 0; i < N; i++) v[i*8 +: 8] = 8'(8'h80 + 8'h10 * k + i);
    return v;
  endfunction

  task automatic do_start(input logic [7:0] k);
    start = 1'b1; k_len = k;
    step();
    start = 1'b0; k_len = '0;
  endtask

  // Beat accepted at edge E lands on lane i at cycle E+i; last beat also books done at E+N-1.
  task automatic beat(input logic [63:0] a, input logic [63:0] b, input bit last);
    exp_t e;
    in_valid = 1'b1; in_a = a; in_b = b;
    chk("in_ready_feed", {63'd0, in_ready}, 64'd1);
    step();
    for (int i = 0; i < N; i++) begin
      e.lane = i; e.cyc = cyc + i; e.a = a[i*8 +: 8]; e.b = b[i*8 +: 8];
      sb.push_back(e);
    end
    if (last) done_q.push_back(cyc + N - 1);
    in_valid = 1'b0; in_a = '0; in_b = '0;
  endtask

  task automatic bubble();
    in_valid = 1'b0; in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom};
    step();
    in_a = '0; in_b = '0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((sb.size() != 0 || done_q.size() != 0) && t < 40) begin step(); t++; end
    chk("drain_timeout", 64'(sb.size() + done_q.size()), 64'd0);
    chk("busy_after_tile", {63'd0, busy}, 64'd0);
  endtask

  task automatic all_zero(input string name);
    chk(name, {a_left ^ b_top, 48'd0, a_vld, b_vld}, 64'd0);
    chk({name, "_ab"}, a_left | b_top, 64'd0);
    chk({name, "_ctl"}, {61'd0, in_ready, busy, done}, 64'd0);
  endtask

  task automatic tile_cont();
    do_start(8'd3);
    for (int k = 0; k < 3; k++) beat(mk_a(k), mk_b(k), k == 2);
    chk("in_ready_drain", {63'd0, in_ready}, 64'd0);
    wait_idle();
  endtask

  initial begin
    // 1. reset with random inputs
    repeat (4) begin
      start = 1'($urandom); k_len = 8'($urandom); in_valid = 1'($urandom);
      in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom};
      #3; all_zero("reset_out"); #7;
    end
    start = 0; k_len = 0; in_valid = 0; in_a = '0; in_b = '0;
    #2 rst = 1'b1;
    step(); step();
    chk("post_reset_ctl", {62'd0, in_ready, busy}, 64'd0);

    // 2. continuous tile
    tile_cont();

    // 3. bubble between beats 0 and 1
    do_start(8'd3);
    beat(mk_a(0), mk_b(0), 0);
    bubble();
    beat(mk_a(1), mk_b(1), 0);
    beat(mk_a(2), mk_b(2), 1);
    wait_idle();

    // 4. single beat
    do_start(8'd1);
    beat(64'h0102030405060708, 64'hF1F2F3F4F5F6F7F8, 1);
    chk("in_ready_single", {63'd0, in_ready}, 64'd0);
    wait_idle();

    // 5. ignored starts: k_len=0, then mid-tile start
    do_start(8'd0);
    chk("k0_busy", {62'd0, in_ready, busy}, 64'd0);
    step();
    chk("k0_busy_later", {62'd0, in_ready, busy}, 64'd0);
    do_start(8'd3);
    beat(mk_a(4), mk_b(4), 0);
    start = 1'b1; k_len = 8'd5;
    beat(mk_a(5), mk_b(5), 0);
    start = 1'b0; k_len = '0;
    beat(mk_a(6), mk_b(6), 1);
    wait_idle();
    step(); step();
    chk("no_restart", {62'd0, in_ready, busy}, 64'd0);

    // 6. async reset mid-feed
    do_start(8'd5);
    beat(mk_a(0), mk_b(0), 0);
    beat(mk_a(1), mk_b(1), 0);
    in_valid = 1'b1; in_a = mk_a(2); in_b = mk_b(2);
    #2 rst = 1'b0;
    #1 all_zero("midreset_out");
    sb.delete(); done_q.delete();
    in_valid = 1'b0; in_a = '0; in_b = '0;
    step(); step();
    #2 rst = 1'b1;
    step();
    chk("post_midreset_ctl", {62'd0, in_ready, busy}, 64'd0);
    tile_cont();

    step(); step();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
